// File: rtl/fir_stream_driver.sv
// Source-side driver for the 16-tap load/compute FIR: FIFO in, prime, one sample per result, result register out.
// Optional FIR_DRV_STAT_EN adds saturating underrun/overrun counters (udr_cnt, ovr_cnt).
module fir_stream_driver #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int TAPS  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          fir_en,
  output logic [DW-1:0] fir_x,
  input  logic          fir_busy,
  input  logic          fir_valid,
  input  logic [DW-1:0] fir_y,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          underrun,
  output logic          overrun
`ifdef FIR_DRV_STAT_EN
  ,
  output logic [15:0]   udr_cnt,
  output logic [15:0]   ovr_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_PRIME, S_RUN} state_t;

  state_t          r_state, w_next;
  logic            w_kick;
  logic [PW-1:0]   r_pcnt;
  logic            r_start_pend;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            w_empty, w_push, w_pop, w_slot, w_take;

  assign w_empty  = (r_cnt == '0);
  assign in_ready = (r_cnt != CW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  // Load slot: the filter has a result up and is not computing.
  assign w_slot   = (r_state == S_RUN) && fir_valid && !fir_busy;
  assign w_pop    = (r_state == S_PRIME) || (w_slot && !w_empty);
  assign w_take   = w_slot && (!r_out_valid || out_ready);

  assign fir_en    = (r_state != S_IDLE);
  assign fir_x     = w_pop ? r_mem[r_rptr] : '0;
  assign underrun  = w_slot && w_empty;
  assign overrun   = w_slot && !w_take;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_comb begin
    w_next = r_state;
    w_kick = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start_pend && (r_cnt >= CW'(TAPS))) begin
          w_next = S_KICK;
          w_kick = 1'b1;
        end
      end
      S_KICK:  w_next = S_PRIME;
      S_PRIME: if (r_pcnt == PW'(TAPS-1)) w_next = S_RUN;
      S_RUN:   w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_start_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_KICK)       r_pcnt <= '0;
      else if (r_state == S_PRIME) r_pcnt <= r_pcnt + PW'(1);
      if (w_kick)                               r_start_pend <= 1'b0;
      else if (start && (r_state == S_IDLE))    r_start_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A full register with no downstream accept keeps the older result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= fir_y;
    end else if (!w_slot && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef FIR_DRV_STAT_EN
  logic [15:0] r_udr_cnt, r_ovr_cnt;
  assign udr_cnt = r_udr_cnt;
  assign ovr_cnt = r_ovr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_udr_cnt <= '0;
      r_ovr_cnt <= '0;
    end else begin
      if (underrun && (r_udr_cnt != 16'hFFFF)) r_udr_cnt <= r_udr_cnt + 16'd1;
      if (overrun  && (r_ovr_cnt != 16'hFFFF)) r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fir_stream_driver.sv
// Bench for fir_stream_driver: behavioural FIR stub, queue/time-based reference, scenario table plus corner sequences.
module tb_fir_stream_driver;
  localparam int DW = 32, DEPTH = 32, TAPS = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, fir_en, fir_busy, fir_valid;
  logic          out_valid, out_ready, underrun, overrun;
  logic [DW-1:0] in_data, fir_x, fir_y, out_data;
`ifdef FIR_DRV_STAT_EN
  logic [15:0]   udr_cnt, ovr_cnt;
`endif

  fir_stream_driver #(.DW(DW), .DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fir_en(fir_en), .fir_x(fir_x), .fir_busy(fir_busy), .fir_valid(fir_valid), .fir_y(fir_y),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .underrun(underrun), .overrun(overrun)
`ifdef FIR_DRV_STAT_EN
    , .udr_cnt(udr_cnt), .ovr_cnt(ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            kick = -1;
  bit            pend = 1'b0;
  bit            m_ov = 1'b0;
  logic [DW-1:0] m_od = '0;
  int            m_udr = 0, m_ovr = 0;

  // FIR stub state: sk = cycle index relative to KICK, -1 before KICK
  int            sk = -1;
  logic [DW-1:0] dl [TAPS];
  int            coef [TAPS];

  // Observed DUT pulse counts for the current scenario
  int n_acc = 0, n_udr = 0, n_ovr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] fir_calc();
    longint unsigned acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(coef[i]) * longint'(dl[i]);
    return DW'(acc >> 16);
  endfunction

  task automatic step();
    int sz;
    bit prime, slot, pop, idle;
    logic p_rst, p_iv, p_st, p_ordy, p_v, p_en;
    logic [DW-1:0] p_id, p_y, p_x, ex;
    #1;
    sz    = q.size();
    prime = (kick >= 0) && (cyc >= kick + 1) && (cyc <= kick + TAPS);
    slot  = (kick >= 0) && (cyc >= kick + TAPS + 1) && (fir_valid === 1'b1);
    pop   = prime || (slot && sz > 0);
    ex    = pop ? q[0] : '0;
    if (chk_en) begin
      chk("in_ready",  in_ready,  sz != DEPTH);
      chk("fir_en",    fir_en,    (kick >= 0) && (cyc >= kick));
      chk("fir_x",     fir_x,     ex);
      chk("underrun",  underrun,  slot && sz == 0);
      chk("overrun",   overrun,   slot && m_ov && !out_ready);
      chk("out_valid", out_valid, m_ov);
      chk("out_data",  out_data,  m_od);
    end
    if (out_valid === 1'b1 && out_ready) n_acc++;
    if (underrun === 1'b1) n_udr++;
    if (overrun === 1'b1) n_ovr++;
    p_rst = rst_n; p_iv = in_valid; p_id = in_data; p_st = start; p_ordy = out_ready;
    p_v = fir_valid; p_y = fir_y; p_en = fir_en; p_x = fir_x;
    @(posedge clk);
    #1;
    // FIR stub
    if (!p_rst) begin
      sk = -1;
      for (int i = 0; i < TAPS; i++) dl[i] = '0;
    end else if (sk < 0) begin
      if (p_en === 1'b1) sk = 1;
    end else begin
      if ((sk >= 1 && sk <= TAPS) || p_v) begin
        for (int i = TAPS - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = p_x;
      end
      sk++;
    end
    fir_valid = (sk >= 33) && ((sk - 33) % 17 == 0);
    fir_busy  = (sk >= 17) && !fir_valid;
    fir_y     = fir_valid ? fir_calc() : '0;
    // Reference model
    if (!p_rst) begin
      q.delete(); kick = -1; pend = 0; m_ov = 0; m_od = '0; m_udr = 0; m_ovr = 0;
    end else begin
      idle = (kick < 0);
      if (slot && sz == 0 && m_udr < 16'hFFFF) m_udr++;
      if (slot && m_ov && !p_ordy && m_ovr < 16'hFFFF) m_ovr++;
      if (slot) begin
        if (!m_ov || p_ordy) begin m_ov = 1; m_od = p_y; end
      end else if (p_ordy) m_ov = 0;
      if (idle && pend && sz >= TAPS) begin kick = cyc + 1; pend = 0; end
      else if (p_st && idle) pend = 1;
      if (pop) void'(q.pop_front());
      if (p_iv && sz < DEPTH) q.push_back(p_id);
    end
    cyc++;
  endtask

  task automatic do_reset();
    chk_en = 0; rst_n = 0; start = 0; in_valid = 0; in_data = '0; out_ready = 0;
    step();
    #1;
    chk("rst_fir_en", fir_en, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pulses", {underrun, overrun}, 0);
    step();
    rst_n = 1; chk_en = 1;
  endtask

  task automatic push_n(input int n, input bit dc);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = dc ? 32'd1 : $urandom;
      step();
    end
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc = -1;
    step();
    start = 0;
  endtask

  typedef struct {
    string nm;
    int npre; int feed; bit dc; int ordy;
    int exp_acc; int exp_udr; int exp_ovr; int exp_last;
  } scen_t;

  initial begin
    scen_t tbl[6];
    logic [DW-1:0] smp [TAPS];
    int p;
    coef[0] = 4108;
    for (int i = 1; i < TAPS; i++) coef[i] = 4096;
    for (int i = 0; i < TAPS; i++) dl[i] = '0;
    fir_valid = 0; fir_busy = 0; fir_y = '0;

    tbl[0] = '{"dc",        16, 1, 1, 1,  6, 0,  0,  1};
    tbl[1] = '{"underrun",  16, 0, 0, 1,  6, 6,  0, -1};
    tbl[2] = '{"rand_feed", 20, 2, 0, 1,  6, 0,  0, -1};
    tbl[3] = '{"backpress", 16, 1, 0, 0,  0, 0,  5, -1};
    tbl[4] = '{"rand_rdy",  24, 2, 0, 2, -1, 0, -1, -1};
    tbl[5] = '{"udr_bp",    16, 0, 0, 0,  0, 6,  5, -1};

    for (int t = 0; t < 6; t++) begin
      do_reset();
      push_n(tbl[t].npre, tbl[t].dc);
      n_acc = 0; n_udr = 0; n_ovr = 0;
      pulse_start();
      while (cyc < 121) begin
        case (tbl[t].feed)
          1:       in_valid = 1;
          2:       in_valid = $urandom_range(1, 0);
          default: in_valid = 0;
        endcase
        in_data   = tbl[t].dc ? 32'd1 : $urandom;
        out_ready = (tbl[t].ordy == 2) ? 1'($urandom_range(1, 0)) : (tbl[t].ordy == 1);
        step();
      end
      in_valid = 0;
      if (tbl[t].exp_acc >= 0) chk({tbl[t].nm, "_acc"}, n_acc, tbl[t].exp_acc);
      if (tbl[t].exp_udr >= 0) chk({tbl[t].nm, "_udr"}, n_udr, tbl[t].exp_udr);
      if (tbl[t].exp_ovr >= 0) chk({tbl[t].nm, "_ovr"}, n_ovr, tbl[t].exp_ovr);
      if (tbl[t].exp_last >= 0) chk({tbl[t].nm, "_last"}, out_data, tbl[t].exp_last);
`ifdef FIR_DRV_STAT_EN
      chk({tbl[t].nm, "_udr_cnt"}, udr_cnt, m_udr);
      chk({tbl[t].nm, "_ovr_cnt"}, ovr_cnt, m_ovr);
`endif
    end

    // Priming timing with explicit sample values
    do_reset();
    for (int i = 0; i < TAPS; i++) begin
      smp[i] = $urandom; in_valid = 1; in_data = smp[i];
      step();
    end
    in_valid = 0; out_ready = 1;
    pulse_start();
    while (cyc < 37) begin
      #1;
      if (cyc == 0) chk("prime_en0", fir_en, 0);
      if (cyc == 1) chk("prime_kick", {fir_en, fir_x}, {1'b1, 32'd0});
      if (cyc >= 2 && cyc <= 17) chk("prime_x", fir_x, smp[cyc-2]);
      if (cyc == 34) chk("prime_udr", {underrun, fir_x}, {1'b1, 32'd0});
      if (cyc == 34) chk("prime_ov34", out_valid, 0);
      if (cyc == 35) chk("prime_ov35", out_valid, 1);
      step();
    end

    // Late data: only 10 samples at start
    do_reset();
    push_n(10, 0);
    pulse_start();
    repeat (5) step();
    #1 chk("late_idle", fir_en, 0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = $urandom; p = cyc;
      step();
    end
    in_valid = 0;
    #1 chk("late_en_p1", fir_en, 0);
    step();
    #1 chk("late_kick", fir_en, 1);
    chk("late_kick_cyc", cyc, p + 2);
    repeat (40) step();

    // Full FIFO, rejected push, then reset mid-RUN
    do_reset();
    push_n(DEPTH, 0);
    #1 chk("full_in_ready", in_ready, 0);
    in_valid = 1; in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 0;
    #1 chk("full_still", in_ready, 0);
    pulse_start();
    while (cyc < 60) step();
    #1 chk("run_ov", out_valid, 1);
    rst_n = 0;
    step();
    #1;
    chk("mid_rst_en", fir_en, 0);
    chk("mid_rst_x", fir_x, 0);
    chk("mid_rst_ordy", in_ready, 1);
    chk("mid_rst_out", {out_valid, out_data}, 0);
    chk("mid_rst_pulse", {underrun, overrun}, 0);
    rst_n = 1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Source-side driver for the team's 16-tap load/compute FIR (enable/x in, busy/valid/y out).
- Takes samples from an upstream valid/ready stream into a FIFO and primes the filter with TAPS samples.
- In steady state it feeds exactly one new sample per filter result, in the filter's single load slot.
- Captures each filter result into a downstream valid/ready output register.

Parameters:
- DW, 32, sample and result width.
- DEPTH, 32, input FIFO depth; power of two, and must be at least TAPS.
- TAPS, 16, filter taps; also the number of priming samples.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to begin streaming
- in_valid  in  1  upstream sample valid
- in_data  in  DW  upstream sample
- in_ready  out  1  FIFO not full
- fir_en  out  1  filter enable
- fir_x  out  DW  sample presented to the filter
- fir_busy  in  1  filter computing
- fir_valid  in  1  filter result valid; this is also the filter's load slot
- fir_y  in  DW  filter result
- out_valid  out  1  result held
- out_data  out  DW  result
- out_ready  in  1  downstream accept
- underrun  out  1  pulse: load slot taken with the FIFO empty
- overrun  out  1  pulse: result dropped because the output register was full

Behaviour:
- Reset values:
  - all outputs 0, except in_ready=1
  - FIFO empty, state IDLE, start_pend=0
  - reset mid-stream aborts immediately; the filter shares rst_n, so both restart cleanly.
- FIFO:
  - write when in_valid&&in_ready; in_ready = (count!=DEPTH).
  - simultaneous push and pop when full is not allowed (in_ready=0 when full).
  - push and pop in the same cycle when not full: count unchanged.
  - pointers wrap modulo DEPTH.
- start:
  - registered into start_pend.
  - start while not in IDLE is ignored.
- FSM states: IDLE, KICK, PRIME, RUN.
  - IDLE: fir_en=0. Go to KICK when start_pend && count>=TAPS; clear start_pend.
  - KICK: one cycle; fir_en=1, fir_x=0. Next state PRIME, prime counter=0.
  - PRIME: fir_en=1.
    - Each cycle pop FIFO head onto fir_x.
    - After TAPS cycles go to RUN.
    - No underrun is possible here, because count>=TAPS was checked on entry.
  - RUN:
    - fir_en=1; fir_x is 0 except in a load slot.
    - Load slot = any cycle with fir_valid=1 (fir_busy=0). In that cycle: pop FIFO head onto fir_x.
    - If the FIFO is empty in a load slot: fir_x=0 and underrun=1 for that cycle.
    - RUN exits only by reset, because the filter never returns to idle.
- fir_x is combinational from the FIFO head during PRIME and load slots; no pop happens on any other cycle.
- Output register:
  - on fir_valid, if !out_valid || out_ready: out_data<=fir_y, out_valid<=1.
  - otherwise keep the old result and pulse overrun (1 cycle).
  - out_valid clears on out_ready when there is no new fir_valid.
  - fir_valid seen in IDLE/KICK/PRIME is ignored (no capture, no pop).
- Timing, with start registered at edge 0:
  - KICK is cycle 1; samples 0..15 go out in cycles 2..17.
  - First fir_valid is expected at cycle 34; out_valid rises at cycle 35.
  - Then one result every 17 cycles.

Optional Feature:
- Macro FIR_DRV_STAT_EN.
- With it defined: add output ports udr_cnt[15:0] and ovr_cnt[15:0].
  - These count underrun and overrun pulses.
  - Both saturate at 16'hFFFF and reset to 0.
- Without it: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Priming with the FIR attached: push 16 samples, pulse start.
  - fir_en rises at cycle 1; samples 0..15 appear on fir_x in cycles 2..17.
  - FIFO is empty after that; first out_valid at cycle 35.
- DC: stream constant 1, out_ready=1.
  - Every out_data = 1 (coefficient sum 65548>>16).
  - One result per 17 cycles; underrun never asserts.
- Late data: start with 10 samples in the FIFO.
  - Stays IDLE with fir_en=0 until the 16th sample is pushed, then KICK on the next cycle.
- Underrun: prime 16 samples, then push nothing.
  - At the first fir_valid: fir_x=0, underrun=1 for one cycle.
  - Results continue every 17 cycles.
- Backpressure: hold out_ready=0 across two results.
  - First result held; second dropped with overrun=1.
  - out_data still equals the first result.
- Full and reset: push 32 samples with start low.
  - in_ready=0, and a 33rd push is rejected.
  - Assert rst_n=0 mid-RUN: next cycle all outputs are 0, in_ready=1, state IDLE.
